// File: rtl/wash_sequencer.sv
// wash_sequencer: wash-cycle controller feeding the seven-segment display driver.
// Steps the selected program through fill/wash/drain/rinse/spin on one-second ticks.
// Then counts down to auto power-off.
module wash_sequencer #(
    parameter int unsigned CLK_PER_SEC  = 100000000,
    parameter int unsigned TARGET_LEVEL = 5,
    parameter int unsigned WASH_SEC     = 12,
    parameter int unsigned RINSE_SEC    = 8,
    parameter int unsigned SPIN_SEC     = 6,
    parameter int unsigned POWEROFF_SEC = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic [1:0] mode,
    output logic [3:0] water_level,
    output logic [5:0] time_now,
    output logic [5:0] time_all,
    output logic [2:0] stage,
    output logic       if_finish,
    output logic [3:0] counter_power,
    output logic       power_off,
    output logic       valve_in,
    output logic       valve_out,
    output logic       motor
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFill  = 3'd1,
        StWash  = 3'd2,
        StDrain = 3'd3,
        StRinse = 3'd4,
        StSpin  = 3'd5,
        StDone  = 3'd6,
        StOff   = 3'd7
    } state_e;

    localparam int unsigned PRESC_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_PER_SEC - 1);
    localparam logic [3:0] LEVEL_TGT  = 4'(TARGET_LEVEL);
    localparam logic [5:0] WASH_T     = 6'(WASH_SEC);
    localparam logic [5:0] RINSE_T    = 6'(RINSE_SEC);
    localparam logic [5:0] SPIN_T     = 6'(SPIN_SEC);
    localparam logic [3:0] POWEROFF_T = 4'(POWEROFF_SEC);
    // Fill and drain each take TARGET_LEVEL seconds (one level step per tick)
    localparam logic [5:0] TOTAL_FULL  = 6'(4 * TARGET_LEVEL + WASH_SEC + RINSE_SEC + SPIN_SEC);
    localparam logic [5:0] TOTAL_WASH  = 6'(2 * TARGET_LEVEL + WASH_SEC);
    localparam logic [5:0] TOTAL_RINSE = 6'(2 * TARGET_LEVEL + RINSE_SEC + SPIN_SEC);
    localparam logic [5:0] TOTAL_SPIN  = 6'(SPIN_SEC);

    state_e              state_q;
    logic [1:0]          mode_q;
    logic                rinse_pending_q;
    logic [PRESC_W-1:0]  presc_q;
    logic [5:0]          timer_q;
    logic [3:0]          level_q;
    logic [5:0]          time_now_q;
    logic [5:0]          time_all_q;
    logic [3:0]          counter_power_q;
    logic                if_finish_q;
    logic                power_off_q;
    logic                valve_in_q;
    logic                valve_out_q;
    logic                motor_q;

    logic [5:0] total_live;
    logic       running;
    logic       tick;
    logic       start_ok;

    // Actuator pattern {valve_in, valve_out, motor} for a stage
    function automatic logic [2:0] stage_enables(input state_e s);
        case (s)
            StFill:          return 3'b100;
            StDrain:         return 3'b010;
            StWash, StRinse: return 3'b001;
            StSpin:          return 3'b011;
            default:         return 3'b000;
        endcase
    endfunction

    // Program total for the live mode input, plus tick and start qualification
    always_comb begin
        total_live = TOTAL_FULL;
        unique case (mode)
            2'd0: total_live = TOTAL_FULL;
            2'd1: total_live = TOTAL_WASH;
            2'd2: total_live = TOTAL_RINSE;
            2'd3: total_live = TOTAL_SPIN;
        endcase
        running  = (state_q == StFill) || (state_q == StWash) || (state_q == StDrain) ||
                   (state_q == StRinse) || (state_q == StSpin);
        // pause only freezes the active stages; DONE keeps counting toward power-off
        tick     = ((running && !pause) || (state_q == StDone)) && (presc_q == PRESC_LAST);
        start_ok = start && ((state_q == StIdle) || (state_q == StDone));
    end

    // Sequencer: start handling, prescaler, stage progression and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            mode_q          <= 2'd0;
            rinse_pending_q <= 1'b0;
            presc_q         <= '0;
            timer_q         <= '0;
            level_q         <= '0;
            time_now_q      <= '0;
            time_all_q      <= '0;
            counter_power_q <= '0;
            if_finish_q     <= 1'b0;
            power_off_q     <= 1'b0;
            valve_in_q      <= 1'b0;
            valve_out_q     <= 1'b0;
            motor_q         <= 1'b0;
        end else if (start_ok) begin
            mode_q          <= mode;
            time_all_q      <= total_live;
            time_now_q      <= total_live;
            presc_q         <= '0;
            counter_power_q <= '0;
            if_finish_q     <= 1'b0;
            level_q         <= '0;
            // rinse-only program goes straight to RINSE after its first fill
            rinse_pending_q <= (mode == 2'd2);
            if (mode == 2'd3) begin
                state_q <= StSpin;
                timer_q <= SPIN_T;
                {valve_in_q, valve_out_q, motor_q} <= stage_enables(StSpin);
            end else begin
                state_q <= StFill;
                {valve_in_q, valve_out_q, motor_q} <= stage_enables(StFill);
            end
        end else begin
            case (state_q)
                StIdle: begin
                    time_all_q <= total_live;
                    time_now_q <= total_live;
                    presc_q    <= '0;
                end
                StOff: begin
                end
                default: begin
                    if (running && pause) begin
                        {valve_in_q, valve_out_q, motor_q} <= 3'b000;
                    end else begin
                        {valve_in_q, valve_out_q, motor_q} <= stage_enables(state_q);
                        presc_q <= tick ? '0 : presc_q + 1'b1;
                        if (tick) begin
                            if (running && time_now_q != '0) time_now_q <= time_now_q - 6'd1;
                            case (state_q)
                                StFill: begin
                                    level_q <= level_q + 4'd1;
                                    if (level_q == LEVEL_TGT - 4'd1) begin
                                        if (rinse_pending_q) begin
                                            state_q         <= StRinse;
                                            timer_q         <= RINSE_T;
                                            rinse_pending_q <= 1'b0;
                                            {valve_in_q, valve_out_q, motor_q} <=
                                                stage_enables(StRinse);
                                        end else begin
                                            state_q <= StWash;
                                            timer_q <= WASH_T;
                                            {valve_in_q, valve_out_q, motor_q} <=
                                                stage_enables(StWash);
                                        end
                                    end
                                end
                                StWash: begin
                                    timer_q <= timer_q - 6'd1;
                                    if (timer_q == 6'd1) begin
                                        state_q <= StDrain;
                                        // full program refills for a rinse after washing
                                        if (mode_q == 2'd0) rinse_pending_q <= 1'b1;
                                        {valve_in_q, valve_out_q, motor_q} <=
                                            stage_enables(StDrain);
                                    end
                                end
                                StRinse: begin
                                    timer_q <= timer_q - 6'd1;
                                    if (timer_q == 6'd1) begin
                                        state_q <= StDrain;
                                        {valve_in_q, valve_out_q, motor_q} <=
                                            stage_enables(StDrain);
                                    end
                                end
                                StDrain: begin
                                    level_q <= level_q - 4'd1;
                                    if (level_q == 4'd1) begin
                                        if (rinse_pending_q) begin
                                            state_q <= StFill;
                                            {valve_in_q, valve_out_q, motor_q} <=
                                                stage_enables(StFill);
                                        end else if (mode_q == 2'd1) begin
                                            state_q         <= StDone;
                                            if_finish_q     <= 1'b1;
                                            counter_power_q <= POWEROFF_T;
                                            {valve_in_q, valve_out_q, motor_q} <= 3'b000;
                                        end else begin
                                            state_q <= StSpin;
                                            timer_q <= SPIN_T;
                                            {valve_in_q, valve_out_q, motor_q} <=
                                                stage_enables(StSpin);
                                        end
                                    end
                                end
                                StSpin: begin
                                    timer_q <= timer_q - 6'd1;
                                    if (timer_q == 6'd1) begin
                                        state_q         <= StDone;
                                        if_finish_q     <= 1'b1;
                                        counter_power_q <= POWEROFF_T;
                                        {valve_in_q, valve_out_q, motor_q} <= 3'b000;
                                    end
                                end
                                StDone: begin
                                    if (counter_power_q == '0) begin
                                        state_q     <= StOff;
                                        power_off_q <= 1'b1;
                                        if_finish_q <= 1'b0;
                                    end else begin
                                        counter_power_q <= counter_power_q - 4'd1;
                                    end
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign water_level   = level_q;
    assign time_now      = time_now_q;
    assign time_all      = time_all_q;
    assign stage         = state_q;
    assign if_finish     = if_finish_q;
    assign counter_power = counter_power_q;
    assign power_off     = power_off_q;
    assign valve_in      = valve_in_q;
    assign valve_out     = valve_out_q;
    assign motor         = motor_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// tb_wash_sequencer: directed scenarios plus randomized traffic against a program-level model.
module tb_wash_sequencer;

    localparam int CPS = 4;
    localparam int TL  = 5;
    localparam int WS  = 12;
    localparam int RS  = 8;
    localparam int SS  = 6;
    localparam int PO  = 9;

    localparam int PH_IDLE = 0;
    localparam int PH_RUN  = 1;
    localparam int PH_DONE = 2;
    localparam int PH_OFF  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       pause;
    logic [1:0] mode;
    logic [3:0] water_level;
    logic [5:0] time_now;
    logic [5:0] time_all;
    logic [2:0] stage;
    logic       if_finish;
    logic [3:0] counter_power;
    logic       power_off;
    logic       valve_in;
    logic       valve_out;
    logic       motor;

    always #5 clk = ~clk;

    wash_sequencer #(
        .CLK_PER_SEC  (CPS),
        .TARGET_LEVEL (TL),
        .WASH_SEC     (WS),
        .RINSE_SEC    (RS),
        .SPIN_SEC     (SS),
        .POWEROFF_SEC (PO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .pause         (pause),
        .mode          (mode),
        .water_level   (water_level),
        .time_now      (time_now),
        .time_all      (time_all),
        .stage         (stage),
        .if_finish     (if_finish),
        .counter_power (counter_power),
        .power_off     (power_off),
        .valve_in      (valve_in),
        .valve_out     (valve_out),
        .motor         (motor)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Program described as an ordered list of stages; each stage's cost in seconds
    function automatic int nseg(input int md);
        case (md)
            0:       return 7;
            1:       return 3;
            2:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int seg_stage_of(input int md, input int i);
        int full[7]  = '{1, 2, 3, 1, 4, 3, 5};
        int wonly[3] = '{1, 2, 3};
        int rspin[4] = '{1, 4, 3, 5};
        case (md)
            0:       return full[i];
            1:       return wonly[i];
            2:       return rspin[i];
            default: return 5;
        endcase
    endfunction

    function automatic int seg_len(input int s);
        case (s)
            1, 3:    return TL;
            2:       return WS;
            4:       return RS;
            default: return SS;
        endcase
    endfunction

    function automatic int total_of(input int md);
        int sum;
        sum = 0;
        for (int i = 0; i < nseg(md); i++) sum += seg_len(seg_stage_of(md, i));
        return sum;
    endfunction

    // Model state: phase, seconds elapsed in the program, cycle phase within a second
    int m_phase, m_mode, m_total, m_time_all, m_elapsed, m_presc, m_done_ticks;
    bit m_paused;

    task automatic model_reset();
        m_phase = PH_IDLE; m_mode = 0; m_total = 0; m_time_all = 0;
        m_elapsed = 0; m_presc = 0; m_done_ticks = 0; m_paused = 0;
    endtask

    task automatic model_edge(input logic st, input logic pa, input logic [1:0] md);
        if (st && (m_phase == PH_IDLE || m_phase == PH_DONE)) begin
            m_mode = int'(md); m_total = total_of(m_mode); m_time_all = m_total;
            m_elapsed = 0; m_presc = 0; m_paused = 0; m_phase = PH_RUN;
        end else begin
            case (m_phase)
                PH_IDLE: begin m_time_all = total_of(int'(md)); m_presc = 0; end
                PH_RUN: begin
                    if (pa) m_paused = 1;
                    else begin
                        m_paused = 0;
                        if (m_presc == CPS - 1) begin
                            m_presc = 0; m_elapsed++;
                            if (m_elapsed == m_total) begin m_phase = PH_DONE; m_done_ticks = 0; end
                        end else m_presc++;
                    end
                end
                PH_DONE: begin
                    if (m_presc == CPS - 1) begin
                        m_presc = 0;
                        if (m_done_ticks == PO) m_phase = PH_OFF;
                        else m_done_ticks++;
                    end else m_presc++;
                end
                default: begin end
            endcase
        end
    endtask

    task automatic compare_all();
        int est, elev, etn, efin, ecp, eoff, evi, evo, emo, acc, off, l, s;
        est = 0; elev = 0; etn = 0; efin = 0; ecp = 0; eoff = 0;
        evi = 0; evo = 0; emo = 0; acc = 0; off = 0;
        case (m_phase)
            PH_IDLE: etn = m_time_all;
            PH_RUN: begin
                for (int i = 0; i < nseg(m_mode); i++) begin
                    s = seg_stage_of(m_mode, i);
                    l = seg_len(s);
                    if (m_elapsed >= acc && m_elapsed < acc + l) begin
                        est = s; off = m_elapsed - acc;
                    end
                    acc += l;
                end
                case (est)
                    1:       elev = off;
                    3:       elev = TL - off;
                    5:       elev = 0;
                    default: elev = TL;
                endcase
                etn = m_total - m_elapsed;
                if (!m_paused) begin
                    evi = int'(est == 1);
                    evo = int'(est == 3 || est == 5);
                    emo = int'(est == 2 || est == 4 || est == 5);
                end
            end
            PH_DONE: begin est = 6; efin = 1; ecp = PO - m_done_ticks; end
            default: begin est = 7; eoff = 1; end
        endcase
        check("stage", int'(stage), est);
        check("water_level", int'(water_level), elev);
        check("time_now", int'(time_now), etn);
        check("time_all", int'(time_all), m_time_all);
        check("if_finish", int'(if_finish), efin);
        check("counter_power", int'(counter_power), ecp);
        check("power_off", int'(power_off), eoff);
        check("valve_in", int'(valve_in), evi);
        check("valve_out", int'(valve_out), evo);
        check("motor", int'(motor), emo);
    endtask

    // One clock: drive inputs after the falling edge, model the rising edge, check at next fall
    task automatic cycle(input logic st, input logic pa, input logic [1:0] md);
        start = st; pause = pa; mode = md;
        @(posedge clk);
        model_edge(st, pa, md);
        @(negedge clk);
        compare_all();
    endtask

    // Reset pulse placed between clock edges so its effect is seen without any edge
    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        #1;
        reset = 1'b0;
    endtask

    int          seq_q[$];
    int          last_stage;
    int          n_cyc;
    int          exp_seq[8] = '{1, 2, 3, 1, 4, 3, 5, 6};

    task automatic step_watch(input logic pa);
        cycle(1'b0, pa, 2'd0);
        n_cyc++;
        if (int'(stage) != last_stage) begin
            last_stage = int'(stage);
            seq_q.push_back(last_stage);
        end
    endtask

    initial begin
        int guard;
        int len;
        int pause_left;
        logic [1:0] md;
        logic st, pa;
        logic [1:0] mm;

        reset = 1'b1; start = 1'b0; pause = 1'b0; mode = 2'd0;
        @(negedge clk);
        model_reset();
        compare_all();
        reset = 1'b0;

        // Idle preview of the full program
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 2'd0);
        check("idle_total_full", int'(time_all), 46);
        check("idle_time_now", int'(time_now), 46);

        // Spin-only program through DONE into OFF
        cycle(1'b1, 1'b0, 2'd3);
        check("spin_motor", int'(motor), 1);
        check("spin_valve_out", int'(valve_out), 1);
        for (int i = 0; i < 24; i++) cycle(1'b0, 1'b0, 2'd0);
        check("spin_done_stage", int'(stage), 6);
        check("spin_done_cp", int'(counter_power), 9);
        for (int i = 0; i < 40; i++) cycle(1'b0, 1'b0, 2'd0);
        check("spin_off_stage", int'(stage), 7);
        check("spin_power_off", int'(power_off), 1);
        async_reset();

        // Wash-only program
        cycle(1'b1, 1'b0, 2'd1);
        check("wash_total", int'(time_all), 22);
        guard = 0;
        while (stage != 3'd6 && guard < 200) begin cycle(1'b0, 1'b0, 2'd1); guard++; end
        check("wash_done_cycles", guard, 22 * CPS);
        check("wash_done_time_now", int'(time_now), 0);

        // Full program with a 10-cycle pause inside WASH
        cycle(1'b1, 1'b0, 2'd0);
        seq_q.delete();
        last_stage = int'(stage);
        seq_q.push_back(last_stage);
        n_cyc = 0;
        while (stage != 3'd2 && n_cyc < 100) step_watch(1'b0);
        for (int i = 0; i < 3; i++) step_watch(1'b0);
        for (int i = 0; i < 10; i++) begin
            step_watch(1'b1);
            check("pause_motor", int'(motor), 0);
        end
        while (stage != 3'd6 && n_cyc < 400) step_watch(1'b0);
        check("full_done_cycles", n_cyc, 46 * CPS + 10);
        check("full_seq_len", seq_q.size(), 8);
        for (int i = 0; i < seq_q.size() && i < 8; i++) check("full_seq", seq_q[i], exp_seq[i]);

        // Restart from DONE with counter_power at 4
        guard = 0;
        while (counter_power != 4'd4 && guard < 60) begin cycle(1'b0, 1'b0, 2'd0); guard++; end
        check("done_cp4_reached", int'(counter_power), 4);
        cycle(1'b1, 1'b0, 2'd2);
        check("restart_if_finish", int'(if_finish), 0);
        check("restart_total", int'(time_all), 24);
        check("restart_stage", int'(stage), 1);

        // Reset in RINSE, starts ignored in SPIN and OFF
        guard = 0;
        while (stage != 3'd4 && guard < 100) begin cycle(1'b0, 1'b0, 2'd2); guard++; end
        check("reached_rinse", int'(stage), 4);
        async_reset();
        check("rst_stage", int'(stage), 0);
        check("rst_motor", int'(motor), 0);
        cycle(1'b1, 1'b1, 2'd3);
        check("start_pause_motor", int'(motor), 1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 2'd0);
        cycle(1'b1, 1'b0, 2'd0);
        check("start_in_spin", int'(stage), 5);
        guard = 0;
        while (stage != 3'd7 && guard < 200) begin cycle(1'b0, 1'b0, 2'd0); guard++; end
        check("reached_off", int'(stage), 7);
        cycle(1'b1, 1'b0, 2'd1);
        check("start_in_off", int'(stage), 7);
        async_reset();

        // Randomized traffic: modes, start pulses, pause bursts, occasional resets
        for (int ep = 0; ep < 50; ep++) begin
            len = $urandom_range(300, 60);
            pause_left = 0;
            md = 2'($urandom_range(3, 0));
            if ($urandom_range(3, 0) == 0) async_reset();
            cycle(1'b1, 1'b0, md);
            for (int c = 0; c < len; c++) begin
                if (pause_left == 0 && $urandom_range(15, 0) == 0)
                    pause_left = $urandom_range(12, 1);
                pa = (pause_left > 0);
                if (pause_left > 0) pause_left--;
                st = ($urandom_range(39, 0) == 0);
                mm = 2'($urandom_range(3, 0));
                cycle(st, pa, mm);
                if ($urandom_range(499, 0) == 0) async_reset();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wash_sequencer.md
Name: wash_sequencer

Overview:
Wash-cycle controller that sits directly upstream of the seven-segment display driver. It runs the selected wash program through fill, wash, drain, rinse and spin stages, counting in one-second ticks. It produces the water level, remaining time, total time, finish flag, auto-power-off countdown and power-off flag that the display driver consumes. It also drives the inlet valve, outlet valve and motor enables.

Parameters:
CLK_PER_SEC, 100000000, clk cycles per one-second tick (benches use 4)
TARGET_LEVEL, 5, fill level reached in FILL, 1..9
WASH_SEC, 12, WASH stage duration in seconds
RINSE_SEC, 8, RINSE stage duration in seconds
SPIN_SEC, 6, SPIN stage duration in seconds
POWEROFF_SEC, 9, auto-power-off countdown start value, 1..9
Constraint: every program total must be ≤63. Defaults give a maximum of 46.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high; clears all state
start  in  1  one-cycle pulse; starts the selected program
pause  in  1  level; freezes the running program while high
mode  in  2  program: 0 full, 1 wash-only, 2 rinse+spin, 3 spin-only
water_level  out  4  current water level, 0..TARGET_LEVEL
time_now  out  6  remaining program seconds
time_all  out  6  total program seconds
stage  out  3  current state encoding
if_finish  out  1  high in DONE
counter_power  out  4  auto-power-off seconds remaining
power_off  out  1  high in OFF
valve_in  out  1  inlet valve enable
valve_out  out  1  outlet valve enable
motor  out  1  drum motor enable

Behaviour:
- Reset values: stage=IDLE(0), all outputs 0, prescaler 0, stage timer 0, latched mode 0.
- State encoding: IDLE=0, FILL=1, WASH=2, DRAIN=3, RINSE=4, SPIN=5, DONE=6, OFF=7.
- Stage sequences:
  - mode0: FILL→WASH→DRAIN→FILL→RINSE→DRAIN→SPIN→DONE
  - mode1: FILL→WASH→DRAIN→DONE
  - mode2: FILL→RINSE→DRAIN→SPIN→DONE
  - mode3: SPIN→DONE
- Sequencing: a rinse_pending flag, set from the latched mode at start, selects RINSE versus WASH after FILL and SPIN versus FILL after DRAIN. It is cleared when RINSE is entered.
- Program totals: fill and drain each cost TARGET_LEVEL seconds.
  - mode0: 4·TARGET_LEVEL+WASH_SEC+RINSE_SEC+SPIN_SEC = 46
  - mode1: 2·TARGET_LEVEL+WASH_SEC = 22
  - mode2: 2·TARGET_LEVEL+RINSE_SEC+SPIN_SEC = 24
  - mode3: SPIN_SEC = 6
  - Totals are computed from constants and a mode mux only; no runtime divider.
- IDLE:
  - time_all and time_now track the total for the live mode input every cycle, as a preview.
  - All enables are 0 and the prescaler is held at 0.
- Start:
  - start in IDLE or DONE latches mode, loads time_all and time_now with the program total, and clears the prescaler, counter_power and if_finish.
  - The next state (FILL, or SPIN for mode3) is entered on the same edge.
  - start in any other state is ignored.
- Tick generation:
  - The prescaler counts 0..CLK_PER_SEC-1 in FILL through DONE while pause=0.
  - tick is asserted on the cycle where prescaler==CLK_PER_SEC-1, after which the prescaler wraps to 0.
  - pause=1 holds the prescaler and all counters and forces valve_in, valve_out and motor low. State is retained.
  - pause is ignored in IDLE, DONE and OFF.
- Per-tick actions in FILL..SPIN: time_now decrements by 1, saturating at 0.
- FILL:
  - valve_in=1.
  - water_level increments on each tick.
  - On the tick where the level becomes TARGET_LEVEL, the next stage is entered on the same edge.
- DRAIN:
  - valve_out=1.
  - water_level decrements on each tick.
  - On the tick where the level becomes 0, the next stage is entered on the same edge.
- WASH, RINSE, SPIN:
  - motor=1; SPIN also drives valve_out=1.
  - The stage timer is loaded with the stage duration on entry and decrements per tick.
  - On the tick where the timer reaches 0, the next stage is entered.
- Final tick: time_now reaches 0 on exactly the tick that enters DONE.
- DONE:
  - if_finish=1.
  - counter_power is loaded with POWEROFF_SEC on entry and decrements per tick.
  - The tick where counter_power is 0 enters OFF.
- OFF:
  - power_off=1, if_finish=0, all enables 0.
  - Exits only through reset; start is ignored.
- Simultaneous events:
  - start and pause in the same cycle: start is accepted, and the pause takes effect from the next cycle.
  - A reset assertion at any point returns the block to IDLE immediately (asynchronous), regardless of the current state.
- Width rules: all counters are unsigned. time_now must never underflow. water_level never exceeds TARGET_LEVEL.

Test Plan:
1. Reset then mode=0, CLK_PER_SEC=4, no start → time_all=time_now=46, stage=0, all enables 0.
2. mode=3, start → SPIN with motor=valve_out=1; time_now steps 6→0 every 4 clocks; DONE after 24 clocks with if_finish=1 and counter_power=9; 40 clocks later stage=OFF and power_off=1.
3. mode=1, start → water_level counts 1..5 in FILL; WASH lasts 12 ticks; DRAIN counts 5→0; DONE at tick 22 with time_now=0.
4. mode=0 run: pause=1 for 10 clocks mid-WASH → time_now, water_level and prescaler frozen, motor=0; after release the program completes at tick 46 with stage sequence 1,2,3,1,4,3,5,6.
5. In DONE with counter_power=4, start with mode=2 → if_finish=0, time_all=24, stage=FILL.
6. Reset asserted mid-RINSE and start pulses issued during SPIN and OFF → the reset returns all outputs to 0 asynchronously and stage to IDLE; each start pulse during SPIN and OFF leaves stage unchanged.
